// File: rtl/ucode_loader.sv
// Host-link loader for the microcode sequencer: parses LOAD/LOOP byte frames, writes
// 16-bit words into the control ROM, checks the XOR checksum and optionally launches.
module ucode_loader #(
    parameter bit         AUTO_START = 1'b1,
    parameter logic [7:0] HDR_LOAD   = 8'hA5,
    parameter logic [7:0] HDR_LOOP   = 8'h5A
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    input  logic [7:0]  in_data,
    output logic        in_ready,
    input  logic        abort_i,
    input  logic        seq_ready,
    output logic        rom_we,
    output logic [7:0]  rom_waddr,
    output logic [15:0] rom_wdata,
    output logic        seq_start,
    output logic [7:0]  loop_addr,
    output logic        busy,
    output logic        done,
    output logic [1:0]  err
);

    typedef enum logic [3:0] {
        StIdle, StAddr, StCnt, StDhi, StDlo, StCsum, StLaddr, StLcsum, StLaunch
    } state_t;

    state_t      state_q, state_d;
    logic [7:0]  ptr_q, ptr_d;
    logic [8:0]  cnt_q, cnt_d;
    logic [7:0]  hi_q, hi_d;
    logic [7:0]  xor_q, xor_d;
    logic [7:0]  laddr_q, laddr_d;

    logic        in_ready_q, in_ready_d;
    logic        rom_we_q, rom_we_d;
    logic [7:0]  rom_waddr_q, rom_waddr_d;
    logic [15:0] rom_wdata_q, rom_wdata_d;
    logic        seq_start_q, seq_start_d;
    logic [7:0]  loop_addr_q, loop_addr_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;
    logic [1:0]  err_q, err_d;

    logic        accept;
    logic [7:0]  xor_nxt;

    assign accept  = in_valid & in_ready_q;
    assign xor_nxt = xor_q ^ in_data;

    always_comb begin
        state_d     = state_q;
        ptr_d       = ptr_q;
        cnt_d       = cnt_q;
        hi_d        = hi_q;
        xor_d       = xor_q;
        laddr_d     = laddr_q;
        rom_we_d    = 1'b0;
        rom_waddr_d = rom_waddr_q;
        rom_wdata_d = rom_wdata_q;
        seq_start_d = 1'b0;
        loop_addr_d = loop_addr_q;
        done_d      = 1'b0;
        err_d       = err_q;

        // Abort wins over any byte accepted in the same cycle.
        if (abort_i && state_q != StIdle) begin
            state_d = StIdle;
            err_d   = 2'b11;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (accept) begin
                        if (in_data == HDR_LOAD) begin
                            state_d = StAddr;
                            err_d   = 2'b00;
                            xor_d   = 8'h00;
                        end else if (in_data == HDR_LOOP) begin
                            state_d = StLaddr;
                            err_d   = 2'b00;
                            xor_d   = 8'h00;
                        end else begin
                            err_d   = 2'b10;
                        end
                    end
                end
                StAddr: begin
                    if (accept) begin
                        ptr_d   = in_data;
                        xor_d   = xor_nxt;
                        state_d = StCnt;
                    end
                end
                StCnt: begin
                    if (accept) begin
                        cnt_d   = (in_data == 8'h00) ? 9'd256 : {1'b0, in_data};
                        xor_d   = xor_nxt;
                        state_d = StDhi;
                    end
                end
                StDhi: begin
                    if (accept) begin
                        hi_d    = in_data;
                        xor_d   = xor_nxt;
                        state_d = StDlo;
                    end
                end
                StDlo: begin
                    if (accept) begin
                        rom_we_d    = 1'b1;
                        rom_waddr_d = ptr_q;
                        rom_wdata_d = {hi_q, in_data};
                        ptr_d       = ptr_q + 8'd1;
                        cnt_d       = cnt_q - 9'd1;
                        xor_d       = xor_nxt;
                        state_d     = (cnt_q != 9'd1) ? StDhi : StCsum;
                    end
                end
                StCsum: begin
                    if (accept) begin
                        if (xor_nxt == 8'h00) begin
                            done_d  = 1'b1;
                            state_d = AUTO_START ? StLaunch : StIdle;
                        end else begin
                            err_d   = 2'b01;
                            state_d = StIdle;
                        end
                    end
                end
                StLaddr: begin
                    if (accept) begin
                        laddr_d = in_data;
                        xor_d   = xor_nxt;
                        state_d = StLcsum;
                    end
                end
                StLcsum: begin
                    if (accept) begin
                        if (xor_nxt == 8'h00) begin
                            loop_addr_d = laddr_q;
                            done_d      = 1'b1;
                        end else begin
                            err_d       = 2'b01;
                        end
                        state_d = StIdle;
                    end
                end
                StLaunch: begin
                    if (seq_ready) begin
                        seq_start_d = 1'b1;
                        state_d     = StIdle;
                    end
                end
                default: state_d = StIdle;
            endcase
        end

        in_ready_d = (state_d != StLaunch);
        busy_d     = (state_d != StIdle);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= StIdle;
            ptr_q       <= 8'h00;
            cnt_q       <= 9'd0;
            hi_q        <= 8'h00;
            xor_q       <= 8'h00;
            laddr_q     <= 8'h00;
            in_ready_q  <= 1'b0;
            rom_we_q    <= 1'b0;
            rom_waddr_q <= 8'h00;
            rom_wdata_q <= 16'h0000;
            seq_start_q <= 1'b0;
            loop_addr_q <= 8'h00;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            err_q       <= 2'b00;
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            cnt_q       <= cnt_d;
            hi_q        <= hi_d;
            xor_q       <= xor_d;
            laddr_q     <= laddr_d;
            in_ready_q  <= in_ready_d;
            rom_we_q    <= rom_we_d;
            rom_waddr_q <= rom_waddr_d;
            rom_wdata_q <= rom_wdata_d;
            seq_start_q <= seq_start_d;
            loop_addr_q <= loop_addr_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            err_q       <= err_d;
        end
    end

    assign in_ready  = in_ready_q;
    assign rom_we    = rom_we_q;
    assign rom_waddr = rom_waddr_q;
    assign rom_wdata = rom_wdata_q;
    assign seq_start = seq_start_q;
    assign loop_addr = loop_addr_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign err       = err_q;

endmodule
